// File: rtl/neuron_feeder.sv
// Serial-to-parallel feeder for a single neuron. It collects NEURON_SIZE (x, w) beats,
// fires the neuron once, then holds the captured result until the consumer takes it.
module neuron_feeder #(
    parameter int NEURON_SIZE = 4,
    parameter int WORD_SIZE   = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic                                  clr_i,
    input  logic [WORD_SIZE-1:0]                  s_x_i,
    input  logic [WORD_SIZE-1:0]                  s_w_i,
    input  logic                                  s_valid_i,
    output logic                                  s_ready_o,
    output logic [NEURON_SIZE-1:0][WORD_SIZE-1:0] x_o,
    output logic [NEURON_SIZE-1:0][WORD_SIZE-1:0] weights_o,
    output logic                                  en_o,
    input  logic [WORD_SIZE-1:0]                  result_i,
    output logic [WORD_SIZE-1:0]                  m_result_o,
    output logic                                  m_valid_o,
    input  logic                                  m_ready_i
);

    localparam int CNT_W = (NEURON_SIZE > 1) ? $clog2(NEURON_SIZE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NEURON_SIZE - 1);

    typedef enum logic [1:0] {LOAD, FIRE, WAIT, OUT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             live;
    logic             accept;

    // live keeps s_ready_o low while reset is held and rises on the first edge after release
    assign s_ready_o = live && (state == LOAD) && !clr_i;
    assign accept    = s_valid_i && s_ready_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= LOAD;
            cnt        <= '0;
            live       <= 1'b0;
            en_o       <= 1'b0;
            m_valid_o  <= 1'b0;
            m_result_o <= '0;
            x_o        <= '0;
            weights_o  <= '0;
        end else begin
            live <= 1'b1;
            en_o <= 1'b0;
            if (clr_i) begin
                state     <= LOAD;
                cnt       <= '0;
                m_valid_o <= 1'b0;
                x_o       <= '0;
                weights_o <= '0;
            end else begin
                case (state)
                    LOAD: begin
                        if (accept) begin
                            for (int i = 0; i < NEURON_SIZE; i++) begin
                                if (cnt == CNT_W'(i)) begin
                                    x_o[i]       <= s_x_i;
                                    weights_o[i] <= s_w_i;
                                end
                            end
                            if (cnt == CNT_LAST) begin
                                cnt   <= '0;
                                state <= FIRE;
                                en_o  <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    FIRE: state <= WAIT;
                    WAIT: begin
                        // neuron output registered on the FIRE->WAIT edge is stable here
                        m_result_o <= result_i;
                        state      <= OUT;
                    end
                    OUT: begin
                        // m_valid_o rises one cycle into OUT and drops with the handshake
                        if (m_valid_o && m_ready_i) begin
                            m_valid_o <= 1'b0;
                            state     <= LOAD;
                        end else begin
                            m_valid_o <= 1'b1;
                        end
                    end
                    default: state <= LOAD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_neuron_feeder.sv
// Directed bench for neuron_feeder: full loads, gapped loads, result hold, clear and
// asynchronous reset, all against hand-computed values.
module tb_neuron_feeder;

    localparam int NS = 4;
    localparam int WS = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               clr = 1'b0;
    logic               s_valid = 1'b0;
    logic               m_ready = 1'b0;
    logic [WS-1:0]      s_x = '0;
    logic [WS-1:0]      s_w = '0;
    logic [WS-1:0]      result = '0;
    logic               s_ready;
    logic               en;
    logic               m_valid;
    logic [NS-1:0][WS-1:0] x_v;
    logic [NS-1:0][WS-1:0] w_v;
    logic [WS-1:0]      m_result;

    int n_cmp = 0;
    int n_err = 0;
    int en_cnt = 0;
    int en_base;

    always #5 clk = ~clk;

    neuron_feeder #(.NEURON_SIZE(NS), .WORD_SIZE(WS)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .clr_i      (clr),
        .s_x_i      (s_x),
        .s_w_i      (s_w),
        .s_valid_i  (s_valid),
        .s_ready_o  (s_ready),
        .x_o        (x_v),
        .weights_o  (w_v),
        .en_o       (en),
        .result_i   (result),
        .m_result_o (m_result),
        .m_valid_o  (m_valid),
        .m_ready_i  (m_ready)
    );

    // en_o lasts one full cycle, so each pulse is seen at exactly one falling edge
    always @(negedge clk) if (en) en_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [WS-1:0] x, input logic [WS-1:0] w);
        s_x = x;
        s_w = w;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        s_x = 16'hDEAD;
        s_w = 16'hBEEF;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_en", en, 0);
        check("rst_x", x_v, 0);
        check("rst_w", w_v, 0);
        check("rst_m_result", m_result, 0);
        #9 rst_n = 1'b1;
        tick();
        check("post_rst_s_ready", s_ready, 1);

        // back-to-back load, latency of en_o and m_valid_o
        en_base = en_cnt;
        beat(16'd1, 16'd5);
        beat(16'd2, 16'd6);
        beat(16'd3, 16'd7);
        beat(16'd4, 16'd8);
        check("b2b_x", x_v, {16'd4, 16'd3, 16'd2, 16'd1});
        check("b2b_w", w_v, {16'd8, 16'd7, 16'd6, 16'd5});
        check("b2b_en_T", en, 1);
        check("b2b_s_ready_fire", s_ready, 0);
        result = 16'h00AB;
        tick();
        check("b2b_en_T1", en, 0);
        check("b2b_m_valid_T1", m_valid, 0);
        tick();
        check("b2b_m_valid_T2", m_valid, 0);
        check("b2b_m_result_T2", m_result, 16'h00AB);
        tick();
        check("b2b_m_valid_T3", m_valid, 1);
        check("b2b_en_pulses", en_cnt - en_base, 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("b2b_m_valid_drop", m_valid, 0);
        check("b2b_back_to_load", s_ready, 1);

        // gapped load: idle cycles leave cnt and vectors untouched
        en_base = en_cnt;
        tick(); tick();
        beat(16'd11, 16'd21);
        beat(16'd12, 16'd22);
        check("gap_partial_x", x_v, {16'd4, 16'd3, 16'd12, 16'd11});
        repeat (5) tick();
        check("gap_idle_en", en_cnt - en_base, 0);
        check("gap_idle_x", x_v, {16'd4, 16'd3, 16'd12, 16'd11});
        beat(16'd13, 16'd23);
        tick();
        beat(16'd14, 16'd24);
        check("gap_x", x_v, {16'd14, 16'd13, 16'd12, 16'd11});
        check("gap_w", w_v, {16'd24, 16'd23, 16'd22, 16'd21});
        result = 16'h1234;
        tick();
        tick();
        result = 16'hFFFF;

        // held result: m_ready_i low, s_valid_i pushed with junk
        s_valid = 1'b1;
        s_x = 16'h5555;
        s_w = 16'hAAAA;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("hold_m_valid", m_valid, 1);
            check("hold_m_result", m_result, 16'h1234);
            check("hold_s_ready", s_ready, 0);
            tick();
        end
        s_valid = 1'b0;
        check("hold_x", x_v, {16'd14, 16'd13, 16'd12, 16'd11});
        check("hold_en_pulses", en_cnt - en_base, 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("hold_release_valid", m_valid, 0);
        check("hold_release_load", s_ready, 1);

        // clear after two beats beats a simultaneous load beat
        en_base = en_cnt;
        beat(16'd7, 16'd9);
        beat(16'd8, 16'd10);
        clr = 1'b1;
        s_valid = 1'b1;
        s_x = 16'h0077;
        s_w = 16'h0099;
        #1;
        check("clr_s_ready", s_ready, 0);
        tick();
        clr = 1'b0;
        s_valid = 1'b0;
        check("clr_x", x_v, 0);
        check("clr_w", w_v, 0);
        beat(16'd31, 16'd41);
        beat(16'd32, 16'd42);
        beat(16'd33, 16'd43);
        beat(16'd34, 16'd44);
        check("fresh_x", x_v, {16'd34, 16'd33, 16'd32, 16'd31});
        check("fresh_w", w_v, {16'd44, 16'd43, 16'd42, 16'd41});
        result = 16'h0042;
        tick(); tick(); tick();
        check("fresh_m_valid", m_valid, 1);
        check("fresh_m_result", m_result, 16'h0042);
        check("fresh_en_pulses", en_cnt - en_base, 1);

        // clear on the same edge as the result handshake
        m_ready = 1'b1;
        clr = 1'b1;
        tick();
        m_ready = 1'b0;
        clr = 1'b0;
        #1;
        check("clr_hs_m_valid", m_valid, 0);
        check("clr_hs_load", s_ready, 1);
        check("clr_hs_x", x_v, 0);
        tick(); tick();
        check("clr_hs_no_second", m_valid, 0);
        check("clr_hs_en_pulses", en_cnt - en_base, 1);

        // asynchronous reset while the result is waiting
        beat(16'd1, 16'd2);
        beat(16'd3, 16'd4);
        beat(16'd5, 16'd6);
        beat(16'd7, 16'd8);
        result = 16'h0BAD;
        tick(); tick(); tick();
        check("pre_rst_m_valid", m_valid, 1);
        rst_n = 1'b0;
        #1;
        check("arst_m_valid", m_valid, 0);
        check("arst_x", x_v, 0);
        check("arst_w", w_v, 0);
        check("arst_m_result", m_result, 0);
        check("arst_s_ready", s_ready, 0);
        #1 rst_n = 1'b1;
        tick();
        check("arst_release_s_ready", s_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
